// File: rtl/axi_ni_request_header_transmitter.sv
// axi_ni_request_header_transmitter: packs one AXI request into a NoC header
// and serialises it into typed flits; reads close the packet, writes hand over to the payload sender.
module axi_ni_request_header_transmitter #(
    parameter int FLIT_WIDTH   = 32,
    parameter int FTYPE_WIDTH  = 2,
    parameter int ROUTE_WIDTH  = 12,
    parameter int SOURCE_WIDTH = 6,
    parameter int CMD_WIDTH    = 2,
    parameter int ATTR_WIDTH   = 4,
    parameter int BLEN_WIDTH   = 8,
    parameter int BSEQ_WIDTH   = 4,
    parameter int BINCR_WIDTH  = 2,
    parameter int BP_WIDTH     = 1,
    parameter int BE_WIDTH     = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter logic [CMD_WIDTH-1:0] CMD_READ = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ROUTE_WIDTH-1:0]  req_route,
    input  logic [SOURCE_WIDTH-1:0] req_source,
    input  logic [CMD_WIDTH-1:0]    req_cmd,
    input  logic [ATTR_WIDTH-1:0]   req_attributes,
    input  logic [BLEN_WIDTH-1:0]   req_burst_length,
    input  logic [BSEQ_WIDTH-1:0]   req_burst_sequence,
    input  logic [BINCR_WIDTH-1:0]  req_burst_increment,
    input  logic [BP_WIDTH-1:0]     req_burst_precise,
    input  logic [BE_WIDTH-1:0]     req_byte_enables,
    input  logic [ID_WIDTH-1:0]     req_id,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    output logic [FLIT_WIDTH-1:0]   flit,
    output logic                    flit_valid,
    input  logic                    flit_stall,
    output logic [1:0]              flit_count,
    output logic                    header_done,
    input  logic                    payload_done,
    output logic                    busy
);
    localparam int BASE_WIDTH    = FLIT_WIDTH - FTYPE_WIDTH;
    localparam int HEADER_LENGTH = ROUTE_WIDTH + SOURCE_WIDTH + CMD_WIDTH + ATTR_WIDTH + BLEN_WIDTH
                                 + BSEQ_WIDTH + BINCR_WIDTH + BP_WIDTH + BE_WIDTH + ID_WIDTH + ADDR_WIDTH;
    localparam int HEADER_FLITS  = (HEADER_LENGTH + BASE_WIDTH - 1) / BASE_WIDTH;
    localparam int PACKED_WIDTH  = HEADER_FLITS * BASE_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_PAYLOAD} state_t;

    state_t                    state, next;
    logic [PACKED_WIDTH-1:0]   header, header_in;
    logic [1:0]                count;
    logic                      read;
    logic                      last;
    logic                      xfer;
    logic [FTYPE_WIDTH-1:0]    ftype;

    // zero-extension fills the unused top bits of the last flit
    assign header_in = PACKED_WIDTH'({req_address, req_id, req_byte_enables, req_burst_precise,
                                      req_burst_increment, req_burst_sequence, req_burst_length,
                                      req_attributes, req_cmd, req_source, req_route});

    assign last  = count == 2'(HEADER_FLITS - 1);
    assign xfer  = state == SEND && !flit_stall;
    assign ftype = count == 2'd0 ? (last && read ? FTYPE_WIDTH'(2'b11) : FTYPE_WIDTH'(2'b10))
                 : (last && read ? FTYPE_WIDTH'(2'b01) : FTYPE_WIDTH'(2'b00));

    assign req_ready   = state == IDLE;
    assign flit_valid  = state == SEND;
    assign busy        = state != IDLE;
    assign flit_count  = count;
    assign header_done = xfer && last && !read;
    assign flit        = flit_valid ? {header[BASE_WIDTH*int'(count) +: BASE_WIDTH], ftype} : '0;

    always_comb begin
        next = state;
        case (state)
            IDLE:         next = req_valid ? SEND : IDLE;
            SEND:         next = xfer && last ? (read ? IDLE : WAIT_PAYLOAD) : SEND;
            WAIT_PAYLOAD: next = payload_done ? IDLE : WAIT_PAYLOAD;
            default:      next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            header <= '0;
            count  <= '0;
            read   <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && req_valid) begin
                header <= header_in;
                read   <= req_cmd == CMD_READ;
                count  <= '0;
            end else if (xfer) begin
                count <= last ? 2'd0 : count + 2'd1;
            end
        end
    end
endmodule

// File: doc/axi_ni_request_header_transmitter.md
# axi_ni_request_header_transmitter

Initiator-side NI block that packs an AXI request into a NoC request header and serialises it into flits. It produces the exact header layout that the target-side header receiver reassembles. It latches one request, emits `HEADER_FLITS` flits with flit-type tags under a stall handshake, then either closes the packet (read) or hands over to the write-payload sender.

## Interface
- `FLIT_WIDTH`, 32: flit width; `BASE_WIDTH = FLIT_WIDTH - FTYPE_WIDTH` header bits per flit.
- `FTYPE_WIDTH`, 2: flit-type field, flit bits [1:0].
- `ROUTE_WIDTH` 12, `SOURCE_WIDTH` 6, `CMD_WIDTH` 2, `ATTR_WIDTH` 4, `BLEN_WIDTH` 8, `BSEQ_WIDTH` 4, `BINCR_WIDTH` 2, `BP_WIDTH` 1, `BE_WIDTH` 4, `ID_WIDTH` 4, `ADDR_WIDTH` 32: header field widths.
- `CMD_READ`, 2'b01: command code for read.
- Derived values:
  - `HEADER_LENGTH` = sum of all field widths (79 at defaults).
  - `HEADER_FLITS` = ceil(`HEADER_LENGTH` / `BASE_WIDTH`) (3 at defaults).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request fields valid.
- `req_ready`  out  1  block can accept a request.
- `req_route`, `req_source`, `req_cmd`, `req_attributes`, `req_burst_length`, `req_burst_sequence`, `req_burst_increment`, `req_burst_precise`, `req_byte_enables`, `req_id`, `req_address`  in  per-parameter widths  header fields.
- `flit`  out  FLIT_WIDTH  outgoing flit.
- `flit_valid`  out  1  `flit` is valid.
- `flit_stall`  in  1  downstream stall; a transfer occurs when `flit_valid && !flit_stall`.
- `flit_count`  out  2  index of the header flit being presented.
- `header_done`  out  1  one-cycle pulse on the transfer of the last write header flit.
- `payload_done`  in  1  payload sender finished the write packet.
- `busy`  out  1  high when the block is not IDLE.

## Operation
- Header vector layout, LSB first, contiguous: route, source, cmd, attributes, burst_length, burst_sequence, burst_increment, burst_precise, byte_enables, id, address. Bits from `HEADER_LENGTH` up to `HEADER_FLITS*BASE_WIDTH-1` are 0.
- Flit k carries `flit[FTYPE_WIDTH+i] = header[BASE_WIDTH*k+i]` and `flit[1:0]` = type.
- Flit types:
  - 2'b10 HEAD for k=0.
  - 2'b00 BODY for middle flits, and for the last flit of a write.
  - 2'b01 TAIL for the last flit of a read.
  - 2'b11 HEAD_TAIL only when `HEADER_FLITS`=1 and the request is a read.
- A request is a read iff `req_cmd == CMD_READ`; this is captured with the header.
- FSM:
  - IDLE: `req_ready`=1. On `req_valid`, register the header and the read flag, clear the counter, go to SEND.
  - SEND: `flit_valid`=1. On each transfer the counter increments. On transfer with counter = `HEADER_FLITS-1`: a read goes to IDLE; a write pulses `header_done` in that same cycle and goes to WAIT_PAYLOAD.
  - WAIT_PAYLOAD: `flit_valid`=0, `req_ready`=0. On `payload_done`, go to IDLE.
- `payload_done` is ignored outside WAIT_PAYLOAD.
- Request inputs are ignored outside IDLE; the header register holds its value until the next accept.
- `flit_stall` held high freezes the counter and `flit`; the flit stays valid and unchanged.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, header 0.
  - Outputs: `req_ready`=1, `flit_valid`=0, `flit`=0, `flit_count`=0, `header_done`=0, `busy`=0.
- Reset mid-packet aborts the packet immediately, with no further flits and no `header_done`.
- Latencies:
  - Request accepted at edge N; flit 0 is valid from cycle N+1.
  - With no stall, flits appear in cycles N+1..N+`HEADER_FLITS`.
  - For a read, `req_ready` is high again in cycle N+`HEADER_FLITS`+1. Back-to-back reads have a 1-cycle gap.
- `req_ready`, `flit_valid`, `busy` and `flit_count` decode from registered state; none of them depends combinationally on `req_valid` or `flit_stall`.
- `flit` is driven from registers only.
- `header_done` is combinational: last-flit transfer of a write.
- In WAIT_PAYLOAD, `payload_done` at edge M puts `req_ready` high in cycle M+1.

## Test plan
- Read, no stall (defaults): route=0xABC, source=0x15, cmd=01, address=0x80001234, id=0x9, other fields 0.
  - 3 flits in consecutive cycles with types 10, 00, 01.
  - Flit0[31:2] = header[29:0]; flit2[31:2] upper 11 bits are 0.
  - `req_ready` returns 4 cycles after accept; `header_done` never asserts.
- Write: cmd=10, burst_length=0x0F, byte_enables=0xF.
  - Types 10, 00, 00; `header_done` pulses on flit 2.
  - `busy` stays high and `req_ready`=0 until `payload_done`; idle 1 cycle after it.
- Stall: `flit_stall` high 3 cycles during flit 1.
  - Flit 1 is held stable with `flit_count`=1; then flit 2 follows.
  - Total 3 transfers, no duplicates.
- `req_valid` held high continuously with two different reads: both packets are emitted intact and the second header is not corrupted during the first packet.
- `payload_done` pulsed in IDLE and during SEND: no effect.
- Assert rst low during flit 1 of a write: `flit_valid`=0 and `req_ready`=1 immediately; after release a new read transmits correctly from flit 0.
